// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, NOP encoding,
// fetch step and the fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD,
        DISCARD
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] addr
    );
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: sequential step or word-aligned redirect target.
// Purely combinational; the fetch FSM decides when to load it.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_STEP;
        if (redirect_valid) begin
            next_pc = align_pc(redirect_pc);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect handling.
// Optional FETCH_PERF_CNT_EN adds the fetch_count handshake counter port.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            handshake;
    logic            slot_free;
    logic            pc_load;
    logic            id_load;
    logic            id_clear;

    assign handshake = id_valid && id_ready;
    assign slot_free = !id_valid || id_ready;
    assign imem_addr = pc;

    pc_next_sel u_pc_next_sel (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        pc_load   = 1'b0;
        id_load   = 1'b0;
        id_clear  = handshake;
        unique case (state)
            BOOT: begin
                state_nxt = REQ;
            end
            REQ: begin
                // Never issue while the decode slot is still occupied,
                // so a returning word can always be latched.
                imem_req = slot_free;
                if (redirect_valid) begin
                    pc_load  = 1'b1;
                    id_clear = 1'b1;
                    if (slot_free && !imem_ack) begin
                        state_nxt = DISCARD;
                    end else begin
                        state_nxt = REQ;
                    end
                end else if (slot_free && imem_ack) begin
                    pc_load   = 1'b1;
                    id_load   = 1'b1;
                    state_nxt = id_ready ? REQ : HOLD;
                end else if (!slot_free) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load   = 1'b1;
                    id_clear  = 1'b1;
                    state_nxt = REQ;
                end else if (handshake) begin
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                pc_load = redirect_valid;
                if (imem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= INSTR_NOP;
        end else begin
            state <= state_nxt;
            if (pc_load) begin
                pc <= next_pc;
            end
            if (id_load) begin
                id_valid <= 1'b1;
                id_pc    <= pc;
                id_instr <= imem_rdata;
            end else if (id_clear) begin
                id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (handshake) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (RESET_PC 0 and FFFF_FFFC),
// a simple imem responder, directed stall/redirect/reset scenarios.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en2 = 1'b1;
    logic        rst_n2;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] imem_rdata2;
    logic        id_ready = 1'b0;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        id_valid, id_valid2;
    logic [31:0] id_pc, id_pc2;
    logic [31:0] id_instr, id_instr2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, fetch_count2;
`endif

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   hs_cnt = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   prev_hs = 0;
    logic saw_bad = 1'b0;
    logic auto_mem = 1'b0;
    logic seen = 1'b0;
    logic man_ack = 1'b0;
    logic [31:0] man_data = '0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    assign rst_n2 = rst_n & en2;
    assign imem_rdata2 = imem_addr2 ^ 32'h5A5A_0000;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata2),
        .id_valid(id_valid2), .id_ready(id_ready),
        .id_pc(id_pc2), .id_instr(id_instr2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: ack arrives in the cycle after a request first appears.
    always @(posedge clk) begin
        #2;
        if (!auto_mem) begin
            seen = 1'b0;
            imem_ack = man_ack;
            imem_rdata = man_data;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
            seen = imem_req;
        end else if (imem_req) begin
            if (seen) begin
                imem_ack = 1'b1;
                imem_rdata = imem_addr ^ 32'h5A5A_0000;
            end else begin
                seen = 1'b1;
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each completed decode handshake.
    always @(negedge clk) begin
        if (id_valid && id_instr == 32'hDEAD_BEEF) saw_bad = 1'b1;
        if (rst_n && id_valid && id_ready) begin
            hs_cnt++;
            prev_hs = last_hs;
            last_hs = cyc;
            if (q1.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL dut1 unexpected: got pc %h, none expected", id_pc);
            end else begin
                e1 = q1.pop_front();
                check("dut1 id_pc", id_pc, e1.pc);
                check("dut1 id_instr", id_instr, e1.instr);
            end
        end
        if (rst_n2 && id_valid2 && id_ready) begin
            if (q2.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL dut2 unexpected: got pc %h, none expected", id_pc2);
            end else begin
                e2 = q2.pop_front();
                check("dut2 id_pc", id_pc2, e2.pc);
                check("dut2 id_instr", id_instr2, e2.instr);
            end
        end
    end

    task automatic push1(input logic [31:0] pc, input logic [31:0] instr);
        q1.push_back({pc, instr});
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_cnt < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("handshake count", hs_cnt, n);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int k = 0;
        while (!(imem_req && imem_addr == a) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("request addr", imem_addr, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        auto_mem = 1'b0;
        man_ack = 1'b0;
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset values on both instances.
        repeat (2) @(negedge clk);
        check("rst imem_req", imem_req, 0);
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst id_valid", id_valid, 0);
        check("rst id_pc", id_pc, 32'h0);
        check("rst id_instr", id_instr, 32'h13);
        check("rst2 imem_req", imem_req2, 0);
        check("rst2 imem_addr", imem_addr2, 32'hFFFF_FFFC);
        check("rst2 id_instr", id_instr2, 32'h13);
`ifdef FETCH_PERF_CNT_EN
        check("rst fetch_count", fetch_count, 0);
        check("rst2 fetch_count", fetch_count2, 0);
`endif
        // Sequential fetch, ack one cycle after each request.
        push1(32'h0, 32'h5A5A_0000);
        push1(32'h4, 32'h5A5A_0004);
        push1(32'h8, 32'h5A5A_0008);
        q2.push_back({32'hFFFF_FFFC, 32'hA5A5_FFFC});
        q2.push_back({32'h0000_0000, 32'h5A5A_0000});
        q2.push_back({32'h0000_0004, 32'h5A5A_0004});
        id_ready = 1'b1;
        auto_mem = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("boot imem_req", imem_req, 0);
        check("boot2 imem_req", imem_req2, 0);
        wait_hs(3);
        id_ready = 1'b0;
        check("throughput", last_hs - prev_hs, 2);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count 3", fetch_count, 3);
`endif
        en2 = 1'b0;

        // Decode stall for 5 cycles after first ack.
        do_reset();
        base = hs_cnt;
        push1(32'h0, 32'h5A5A_0000);
        push1(32'h4, 32'h5A5A_0004);
        auto_mem = 1'b1;
        for (int k = 0; k < 40 && !id_valid; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall id_valid", id_valid, 1);
            check("stall id_pc", id_pc, 32'h0);
            check("stall id_instr", id_instr, 32'h5A5A_0000);
            check("stall imem_req", imem_req, 0);
        end
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        wait_addr(32'h4);
        wait_hs(base + 2);
        id_ready = 1'b0;

        // Redirect with request to 0x8 outstanding, then again in DISCARD.
        do_reset();
        base = hs_cnt;
        push1(32'h0, 32'h5A5A_0000);
        push1(32'h4, 32'h5A5A_0004);
        id_ready = 1'b1;
        auto_mem = 1'b1;
        wait_addr(32'h8);
        auto_mem = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(posedge clk);
        #1;
        redirect_pc = 32'h100;
        check("discard imem_req", imem_req, 0);
        check("redirect id_valid", id_valid, 0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        man_ack = 1'b1;
        man_data = 32'hDEAD_BEEF;
        check("discard2 imem_req", imem_req, 0);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        check("post-discard req", imem_req, 1);
        check("post-discard addr", imem_addr, 32'h100);
        push1(32'h100, 32'h5A5A_0100);
        auto_mem = 1'b1;
        wait_hs(base + 3);
        id_ready = 1'b0;

        // Redirect to misaligned 0x203 in the ack cycle.
        do_reset();
        base = hs_cnt;
        push1(32'h0, 32'h5A5A_0000);
        id_ready = 1'b1;
        auto_mem = 1'b1;
        wait_addr(32'h4);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        push1(32'h200, 32'h5A5A_0200);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("ack-drop id_valid", id_valid, 0);
        check("ack-drop req", imem_req, 1);
        check("ack-drop addr", imem_addr, 32'h200);
        wait_hs(base + 2);

        // Reset mid-request with a stray ack during and after reset.
        do_reset();
        base = hs_cnt;
        push1(32'h0, 32'h5A5A_0000);
        id_ready = 1'b1;
        auto_mem = 1'b1;
        wait_hs(base + 1);
        wait_addr(32'h4);
        auto_mem = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async rst req", imem_req, 0);
        check("async rst addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        man_ack = 1'b1;
        man_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("stray id_valid", id_valid, 0);
        check("stray id_instr", id_instr, 32'h13);
        check("stray imem_req", imem_req, 0);
`ifdef FETCH_PERF_CNT_EN
        check("stray fetch_count", fetch_count, 0);
`endif
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        check("restart req", imem_req, 1);
        check("restart addr", imem_addr, 32'h0);
        push1(32'h0, 32'h5A5A_0000);
        auto_mem = 1'b1;
        wait_hs(base + 2);
        id_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count 1", fetch_count, 1);
`endif

        repeat (4) @(negedge clk);
        check("q1 drained", q1.size(), 0);
        check("q2 drained", q2.size(), 0);
        check("dropped word seen", saw_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
